// File: rtl/prog_mod_counter_pkg.sv
// prog_mod_counter_pkg
//   Shared encodings for the programmable-modulus counter: direction and
//   mode codes, plus the one-shot sequencer state type.
package prog_mod_counter_pkg;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
//   Programmable-modulus up/down counter with terminal-count flag, used as the
//   time base of the modulation datapath. The active period, direction and
//   mode only change at a boundary (wrap, sclr or load), so a period written
//   mid-sequence never produces a short or long cycle.
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     en                count enable
//     sclr              synchronous clear to start value (highest priority)
//     load, load_val    synchronous load, value clamped to the new period
//     period_wr, period write terminal value into the pending register
//     dir               0 up, 1 down; sampled at wrap/sclr/load
//     one_shot          0 free-run, 1 one-shot; sampled with dir
//     start             one-shot trigger
//     count             current count (registered)
//     tc                high exactly while count equals the terminal value
//     busy              one-shot run in progress
//     done              one-cycle pulse at the end of a one-shot run
//
//   state | meaning
//   IDLE  | one-shot armed; waits for start, steps ignored
//   RUN   | one-shot counting toward the terminal value
module prog_mod_counter
    import prog_mod_counter_pkg::*;
#(
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  RESET_PERIOD = {WIDTH{1'b1}},
    parameter logic              RESET_DIR    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             period_wr,
    input  logic [WIDTH-1:0] period,
    input  logic             dir,
    input  logic             one_shot,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             RST_TC = (RESET_PERIOD == '0);

    function automatic logic [WIDTH-1:0] term_of(input logic [WIDTH-1:0] p, input logic d);
        return (d == DIR_DOWN) ? '0 : p;
    endfunction

    function automatic logic [WIDTH-1:0] start_of(input logic [WIDTH-1:0] p, input logic d);
        return (d == DIR_DOWN) ? p : '0;
    endfunction

    logic [WIDTH-1:0] p_act_q, p_act_d;
    logic [WIDTH-1:0] p_pend_q, p_pend_d;
    logic             dir_act_q, dir_act_d;
    logic             mode_act_q, mode_act_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    state_t           state_q, state_d;

    logic             at_term;
    logic [WIDTH-1:0] count_step;

    assign at_term    = (count_q == term_of(p_act_q, dir_act_q));
    assign count_step = (dir_act_q == DIR_DOWN) ? (count_q - ONE) : (count_q + ONE);

    always_comb begin
        p_pend_d   = period_wr ? period : p_pend_q;
        p_act_d    = p_act_q;
        dir_act_d  = dir_act_q;
        mode_act_d = mode_act_q;
        count_d    = count_q;
        busy_d     = busy_q;
        state_d    = state_q;
        done_d     = 1'b0;

        if (sclr) begin
            p_act_d    = p_pend_q;
            dir_act_d  = dir;
            mode_act_d = one_shot;
            count_d    = start_of(p_pend_q, dir);
            busy_d     = 1'b0;
            state_d    = IDLE;
        end else if (load) begin
            p_act_d    = p_pend_q;
            dir_act_d  = dir;
            mode_act_d = one_shot;
            count_d    = (load_val > p_pend_q) ? p_pend_q : load_val;
        end else if (mode_act_q == MODE_FREE) begin
            if (en) begin
                if (at_term) begin
                    // Boundary: the pending configuration becomes active here only.
                    p_act_d    = p_pend_q;
                    dir_act_d  = dir;
                    mode_act_d = one_shot;
                    count_d    = start_of(p_pend_q, dir);
                end else begin
                    count_d    = count_step;
                end
            end
        end else begin
            // One-shot runs use the already-active period/direction.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d = start_of(p_act_q, dir_act_q);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (at_term) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            count_d = count_step;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Flag derived from the next count so it lines up with count.
        tc_d = (count_d == term_of(p_act_d, dir_act_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_act_q    <= RESET_PERIOD;
            p_pend_q   <= RESET_PERIOD;
            dir_act_q  <= RESET_DIR;
            mode_act_q <= MODE_FREE;
            count_q    <= start_of(RESET_PERIOD, RESET_DIR);
            tc_q       <= RST_TC;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= IDLE;
        end else begin
            p_act_q    <= p_act_d;
            p_pend_q   <= p_pend_d;
            dir_act_q  <= dir_act_d;
            mode_act_q <= mode_act_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            state_q    <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
module tb_prog_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, sclr = 1'b0, load = 1'b0, period_wr = 1'b0;
    logic       dir = 1'b0, one_shot = 1'b0, start = 1'b0;
    logic [7:0] load_val = 8'd0, period = 8'd0;
    logic [7:0] count;
    logic       tc, busy, done;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state (plain integers)
    int m_p_act, m_p_pend, m_dir, m_mode, m_count, m_busy, m_done;

    int exp_up[7]   = '{1, 2, 3, 4, 5, 0, 1};
    int exp_dn[11]  = '{2, 3, 4, 5, 5, 4, 3, 2, 1, 0, 5};
    int exp_dtc[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int exp_pw[8]   = '{3, 4, 5, 0, 1, 2, 3, 0};
    int exp_oc[7]   = '{0, 1, 2, 3, 4, 4, 4};
    int exp_ob[7]   = '{1, 1, 1, 1, 1, 0, 0};
    int exp_od[7]   = '{0, 0, 0, 0, 0, 1, 0};

    prog_mod_counter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sclr      (sclr),
        .load      (load),
        .load_val  (load_val),
        .period_wr (period_wr),
        .period    (period),
        .dir       (dir),
        .one_shot  (one_shot),
        .start     (start),
        .count     (count),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int term_v(int p, int d);
        return d ? 0 : p;
    endfunction

    function automatic int start_v(int p, int d);
        return d ? p : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the behavioural rules once per rising edge.
    always @(posedge clk or posedge rst) begin : model
        int np;
        int lv;
        if (rst) begin
            m_p_act  = 255;
            m_p_pend = 255;
            m_dir    = 0;
            m_mode   = 0;
            m_count  = 0;
            m_busy   = 0;
            m_done   = 0;
        end else begin
            np     = period_wr ? int'(period) : m_p_pend;
            lv     = int'(load_val);
            m_done = 0;
            if (sclr || load) begin
                m_p_act = m_p_pend;
                m_dir   = int'(dir);
                m_mode  = int'(one_shot);
                if (sclr) begin
                    m_count = start_v(m_p_act, m_dir);
                    m_busy  = 0;
                end else begin
                    m_count = (lv > m_p_act) ? m_p_act : lv;
                end
            end else if (m_mode == 0) begin
                if (en) begin
                    if (m_count == term_v(m_p_act, m_dir)) begin
                        m_p_act = m_p_pend;
                        m_dir   = int'(dir);
                        m_mode  = int'(one_shot);
                        m_count = start_v(m_p_act, m_dir);
                    end else begin
                        m_count = m_count + (m_dir ? -1 : 1);
                    end
                end
            end else if (m_busy == 0) begin
                if (start) begin
                    m_count = start_v(m_p_act, m_dir);
                    m_busy  = 1;
                end
            end else if (en) begin
                if (m_count == term_v(m_p_act, m_dir)) begin
                    m_done = 1;
                    m_busy = 0;
                end else begin
                    m_count = m_count + (m_dir ? -1 : 1);
                end
            end
            m_p_pend = np;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(m_count));
            chk("tc",    32'(tc),    32'(m_count == term_v(m_p_act, m_dir)));
            chk("busy",  32'(busy),  32'(m_busy));
            chk("done",  32'(done),  32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        en = 1'b0; sclr = 1'b0; load = 1'b0; period_wr = 1'b0; start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_tc",    32'(tc),    0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("mdl_rst_period", 32'(m_p_act), 255);
        rst = 1'b0;

        // Up count, P=5
        period_wr = 1'b1; period = 8'd5; tick();
        idle_in(); sclr = 1'b1; dir = 1'b0; one_shot = 1'b0; tick();
        chk("up_start", 32'(count), 0);
        idle_in(); en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("up_count", 32'(count), 32'(exp_up[i]));
            chk("up_tc",    32'(tc),    32'(exp_up[i] == 5));
        end

        // Direction change takes effect at the wrap
        dir = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("dn_count", 32'(count), 32'(exp_dn[i]));
            chk("dn_tc",    32'(tc),    32'(exp_dtc[i]));
        end
        chk("mdl_dn_end", 32'(m_count), 5);

        // Period change mid-sequence completes the current run first
        idle_in(); sclr = 1'b1; dir = 1'b0; tick();
        idle_in(); en = 1'b1; tick(); tick();
        chk("pw_pre", 32'(count), 2);
        for (int i = 0; i < 8; i++) begin
            period_wr = (i == 0); period = 8'd3;
            tick();
            chk("pw_count", 32'(count), 32'(exp_pw[i]));
        end
        chk("mdl_pw_period", 32'(m_p_act), 3);

        // Load clamp and sclr-over-load priority
        idle_in(); period_wr = 1'b1; period = 8'd5; tick();
        idle_in(); load = 1'b1; load_val = 8'd9; tick();
        chk("load_clamp", 32'(count), 5);
        chk("load_tc",    32'(tc),    1);
        sclr = 1'b1; load = 1'b1; load_val = 8'd2; tick();
        chk("sclr_win_count", 32'(count), 0);
        chk("sclr_win_tc",    32'(tc),    0);

        // One-shot, P=4
        idle_in(); period_wr = 1'b1; period = 8'd4; tick();
        idle_in(); sclr = 1'b1; one_shot = 1'b1; dir = 1'b0; tick();
        idle_in(); en = 1'b1; tick(); tick();
        chk("os_idle_count", 32'(count), 0);
        chk("os_idle_busy",  32'(busy),  0);
        for (int i = 0; i < 7; i++) begin
            start = (i < 3);
            tick();
            chk("os_count", 32'(count), 32'(exp_oc[i]));
            chk("os_busy",  32'(busy),  32'(exp_ob[i]));
            chk("os_done",  32'(done),  32'(exp_od[i]));
        end

        // Asynchronous reset in the middle of a one-shot run
        start = 1'b1; tick();
        start = 1'b0; tick(); tick(); tick();
        chk("mid_count", 32'(count), 3);
        chk("mid_busy",  32'(busy),  1);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_busy",  32'(busy),  0);
        chk("arst_tc",    32'(tc),    0);
        @(negedge clk);
        rst = 1'b0; idle_in(); one_shot = 1'b0; dir = 1'b0; en = 1'b1;
        repeat (255) tick();
        chk("rstp_top",    32'(count), 255);
        chk("rstp_top_tc", 32'(tc),    1);
        tick();
        chk("rstp_wrap", 32'(count), 0);

        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            rst       = 1'b0;
            en        = ($urandom_range(0, 99) < 85);
            sclr      = ($urandom_range(0, 99) < 3);
            load      = ($urandom_range(0, 99) < 4);
            period_wr = ($urandom_range(0, 99) < 6);
            period    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 7));
            load_val  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            one_shot  = ($urandom_range(0, 99) < 30);
            start     = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
